// File: rtl/match_sequencer_pkg.sv
// Shared types for the duel-game match sequencer: phases, round results and HP sizing.
// Pure declarations; no timing or flow control of its own.
package match_sequencer_pkg;

   typedef enum logic [2:0] {
      PH_IDLE       = 3'd0,
      PH_COUNTDOWN  = 3'd1,
      PH_PLAY       = 3'd2,
      PH_PAUSE      = 3'd3,
      PH_ROUND_END  = 3'd4,
      PH_MATCH_WIN  = 3'd5,
      PH_MATCH_LOSE = 3'd6
   } phase_e;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_PLAYER = 2'd1,
      RES_ENEMY  = 2'd2,
      RES_DRAW   = 2'd3
   } result_e;

   localparam int HP_MAX = 3;
   localparam int HP_W   = $clog2(HP_MAX + 1);

   // Timeout verdict: the side with more HP left takes the round.
   function automatic result_e hp_compare(input logic [HP_W-1:0] php, input logic [HP_W-1:0] ehp);
      result_e r;
      if (php > ehp)      r = RES_PLAYER;
      else if (ehp > php) r = RES_ENEMY;
      else                r = RES_DRAW;
      return r;
   endfunction

endpackage

// File: rtl/match_sequencer_sec_timer.sv
// Frame divider feeding a seconds down-counter that parks at zero; expire is high while at zero.
// Load takes effect next clk and wins over counting; no backpressure, tick is a bare pulse.
module sec_timer #(
   parameter int FPS   = 60,
   parameter int SEC_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [SEC_W-1:0] load_val,
   input  logic             run,
   input  logic             tick,
   output logic [SEC_W-1:0] sec,
   output logic             expire
);

   localparam int FR_W = (FPS > 1) ? $clog2(FPS) : 1;

   logic [FR_W-1:0] frame;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame <= '0;
         sec   <= '0;
      end else if (load) begin
         frame <= '0;
         sec   <= load_val;
      end else if (run && tick) begin
         if (frame == FR_W'(FPS - 1)) begin
            frame <= '0;
            if (sec != '0) sec <= sec - 1'b1;
         end else begin
            frame <= frame + 1'b1;
         end
      end
   end

   assign expire = (sec == '0);

endmodule

// File: rtl/match_sequencer.sv
// Duel-game match scheduler: phases, round scoring, round clock and datapath enable/re-arm.
// All outputs registered; button edges act one clk after the rise; no backpressure.
module match_sequencer
   import match_sequencer_pkg::*;
#(
   parameter int ROUNDS_TO_WIN = 2,
   parameter int FPS           = 60,
   parameter int COUNTDOWN_SEC = 3,
   parameter int ROUND_SEC     = 90,
   parameter int RESULT_FRAMES = 120
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_frame_tick,
   input  logic            i_select,
   input  logic            i_pause,
   input  logic [HP_W-1:0] i_player_hp,
   input  logic [HP_W-1:0] i_enemy_hp,
   output phase_e          o_phase,
   output logic            o_play_en,
   output logic            o_round_rst,
   output logic [2:0]      o_round_num,
   output logic [1:0]      o_player_wins,
   output logic [1:0]      o_enemy_wins,
   output logic [6:0]      o_time_left,
   output result_e         o_round_result
);

   localparam int HOLD_W = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES + 1) : 1;

   phase_e      state, state_nxt;
   result_e     result, result_nxt, round_res;
   logic [2:0]  round_num, rn_nxt;
   logic [1:0]  pw, pw_nxt, ew, ew_nxt;
   logic        play_en_q, round_rst_q, round_rst_nxt;
   logic        sel_q, sel_prev, pau_q, pau_prev, sel_edge, pau_edge;
   logic        tmr_load, tmr_run, expire;
   logic [6:0]  tmr_val, sec;
   logic [HOLD_W-1:0] hold_cnt;
   logic        hold_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q    <= 1'b0;
         sel_prev <= 1'b0;
         pau_q    <= 1'b0;
         pau_prev <= 1'b0;
      end else begin
         sel_q    <= i_select;
         sel_prev <= sel_q;
         pau_q    <= i_pause;
         pau_prev <= pau_q;
      end
   end

   assign sel_edge = sel_q & ~sel_prev;
   assign pau_edge = pau_q & ~pau_prev;
   assign tmr_run  = (state == PH_COUNTDOWN) || (state == PH_PLAY);

   sec_timer #(.FPS(FPS), .SEC_W(7)) u_sec_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (tmr_run),
      .tick     (i_frame_tick),
      .sec      (sec),
      .expire   (expire)
   );

   // Banner hold restarts from zero every time ROUND_END is entered.
   always_ff @(posedge clk) begin
      if (rst || state != PH_ROUND_END) hold_cnt <= '0;
      else if (i_frame_tick)           hold_cnt <= hold_cnt + 1'b1;
   end

   assign hold_done = i_frame_tick && (hold_cnt == HOLD_W'(RESULT_FRAMES - 1));

   always_comb begin
      state_nxt     = state;
      result_nxt    = result;
      rn_nxt        = round_num;
      pw_nxt        = pw;
      ew_nxt        = ew;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      round_rst_nxt = 1'b0;
      round_res     = RES_NONE;
      unique case (state)
         PH_IDLE: if (sel_edge) begin
            state_nxt     = PH_COUNTDOWN;
            pw_nxt        = '0;
            ew_nxt        = '0;
            rn_nxt        = 3'd1;
            result_nxt    = RES_NONE;
            round_rst_nxt = 1'b1;
            tmr_load      = 1'b1;
            tmr_val       = 7'(COUNTDOWN_SEC);
         end
         PH_COUNTDOWN: if (expire) begin
            state_nxt  = PH_PLAY;
            result_nxt = RES_NONE;
            tmr_load   = 1'b1;
            tmr_val    = 7'(ROUND_SEC);
         end
         PH_PLAY: begin
            // A knockout outranks the clock running out in the same cycle.
            if (i_player_hp == '0 && i_enemy_hp == '0) round_res = RES_DRAW;
            else if (i_player_hp == '0)                round_res = RES_ENEMY;
            else if (i_enemy_hp == '0)                 round_res = RES_PLAYER;
            else if (expire)                           round_res = hp_compare(i_player_hp, i_enemy_hp);
            if (round_res != RES_NONE) begin
               state_nxt  = PH_ROUND_END;
               result_nxt = round_res;
               if (round_res == RES_PLAYER) pw_nxt = pw + 2'd1;
               if (round_res == RES_ENEMY)  ew_nxt = ew + 2'd1;
            end else if (pau_edge) begin
               state_nxt = PH_PAUSE;
            end
         end
         PH_PAUSE: begin
            if (sel_edge) begin
               state_nxt  = PH_IDLE;
               rn_nxt     = '0;
               pw_nxt     = '0;
               ew_nxt     = '0;
               result_nxt = RES_NONE;
               tmr_load   = 1'b1;
            end else if (pau_edge) begin
               state_nxt = PH_PLAY;
            end
         end
         PH_ROUND_END: if (hold_done) begin
            if (pw == 2'(ROUNDS_TO_WIN))      state_nxt = PH_MATCH_WIN;
            else if (ew == 2'(ROUNDS_TO_WIN)) state_nxt = PH_MATCH_LOSE;
            else begin
               state_nxt     = PH_COUNTDOWN;
               rn_nxt        = (round_num == 3'd7) ? 3'd7 : round_num + 3'd1;
               round_rst_nxt = 1'b1;
               tmr_load      = 1'b1;
               tmr_val       = 7'(COUNTDOWN_SEC);
            end
         end
         PH_MATCH_WIN, PH_MATCH_LOSE: if (sel_edge) begin
            state_nxt  = PH_IDLE;
            rn_nxt     = '0;
            pw_nxt     = '0;
            ew_nxt     = '0;
            result_nxt = RES_NONE;
            tmr_load   = 1'b1;
         end
         default: state_nxt = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PH_IDLE;
         result      <= RES_NONE;
         round_num   <= '0;
         pw          <= '0;
         ew          <= '0;
         play_en_q   <= 1'b0;
         round_rst_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         result      <= result_nxt;
         round_num   <= rn_nxt;
         pw          <= pw_nxt;
         ew          <= ew_nxt;
         play_en_q   <= (state_nxt == PH_PLAY);
         round_rst_q <= round_rst_nxt;
      end
   end

   assign o_phase        = state;
   assign o_play_en      = play_en_q;
   assign o_round_rst    = round_rst_q;
   assign o_round_num    = round_num;
   assign o_player_wins  = pw;
   assign o_enemy_wins   = ew;
   assign o_time_left    = sec;
   assign o_round_result = result;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer: expected phase entries are queued by the stimulus and
// checked by a monitor whenever the DUT changes phase.
module tb_match_sequencer;
   import match_sequencer_pkg::*;

   localparam int FPS = 4, CD = 2, RS = 5, RF = 3;

   logic       clk = 1'b0;
   logic       rst, tick, sel, pau;
   logic [1:0] php, ehp;
   phase_e     phase;
   result_e    res;
   logic       play_en, round_rst;
   logic [2:0] rn;
   logic [1:0] pw, ew;
   logic [6:0] tl;

   match_sequencer #(
      .ROUNDS_TO_WIN(2), .FPS(FPS), .COUNTDOWN_SEC(CD), .ROUND_SEC(RS), .RESULT_FRAMES(RF)
   ) dut (
      .clk(clk), .rst(rst), .i_frame_tick(tick), .i_select(sel), .i_pause(pau),
      .i_player_hp(php), .i_enemy_hp(ehp), .o_phase(phase), .o_play_en(play_en),
      .o_round_rst(round_rst), .o_round_num(rn), .o_player_wins(pw), .o_enemy_wins(ew),
      .o_time_left(tl), .o_round_result(res)
   );

   always #5 clk = ~clk;

   typedef struct {
      phase_e     ph;
      logic [2:0] rn;
      logic [1:0] pw;
      logic [1:0] ew;
      result_e    res;
      logic [6:0] tl;
      bit         tl_chk;
   } exp_t;

   exp_t   sb[$];
   int     n_checks = 0, n_fail = 0, rr_seen = 0;
   bit     mon_en = 1'b0, tick_en = 1'b0;
   phase_e last_ph;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_ph(input phase_e ph, input int r, input int p, input int e,
                            input result_e rs, input int t, input bit tc);
      exp_t x;
      x.ph = ph; x.rn = 3'(r); x.pw = 2'(p); x.ew = 2'(e); x.res = rs; x.tl = 7'(t); x.tl_chk = tc;
      sb.push_back(x);
   endtask

   task automatic wait_phase(input phase_e p, input int budget, input string name);
      int k = 0;
      while (phase !== p && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, phase, p);
   endtask

   task automatic wait_tl(input int t, input int budget, input string name);
      int k = 0;
      while (tl !== 7'(t) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, tl, t);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".phase"}, phase, PH_IDLE);
      chk({tag, ".play_en"}, play_en, 0);
      chk({tag, ".round_rst"}, round_rst, 0);
      chk({tag, ".round_num"}, rn, 0);
      chk({tag, ".player_wins"}, pw, 0);
      chk({tag, ".enemy_wins"}, ew, 0);
      chk({tag, ".time_left"}, tl, 0);
      chk({tag, ".result"}, res, RES_NONE);
   endtask

   // One tick every 4 clk, changed on the falling edge.
   initial begin
      tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         tick = tick_en;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // Monitor: every phase change consumes one expected entry.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (round_rst) rr_seen++;
            if (round_rst && play_en) begin
               n_checks++;
               n_fail++;
               $display("FAIL round_rst_with_play_en: got both high, expected exclusive (t=%0t)", $time);
            end
            if (phase != last_ph) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_phase: got %0d, expected no change (t=%0t)", phase, $time);
               end else begin
                  x = sb.pop_front();
                  chk($sformatf("%s.phase", x.ph.name()), phase, x.ph);
                  chk($sformatf("%s.round_num", x.ph.name()), rn, x.rn);
                  chk($sformatf("%s.player_wins", x.ph.name()), pw, x.pw);
                  chk($sformatf("%s.enemy_wins", x.ph.name()), ew, x.ew);
                  chk($sformatf("%s.result", x.ph.name()), res, x.res);
                  if (x.tl_chk) chk($sformatf("%s.time_left", x.ph.name()), tl, x.tl);
                  chk($sformatf("%s.round_rst", x.ph.name()), round_rst, x.ph == PH_COUNTDOWN);
                  chk($sformatf("%s.play_en", x.ph.name()), play_en, x.ph == PH_PLAY);
               end
               last_ph = phase;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nt, k;
      rst = 1'b1; sel = 1'b0; pau = 1'b0; php = 2'd3; ehp = 2'd3;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      last_ph = phase;
      mon_en  = 1'b1;
      tick_en = 1'b1;

      // Match 1, round 1: held select gives a single start; enemy knocked out.
      expect_ph(PH_COUNTDOWN, 1, 0, 0, RES_NONE, CD, 1);
      sel = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_select_phase", phase, PH_COUNTDOWN);
      chk("held_select_rr_pulses", rr_seen, 1);
      sel = 1'b0;
      expect_ph(PH_PLAY, 1, 0, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "r1_play");
      expect_ph(PH_ROUND_END, 1, 1, 0, RES_PLAYER, 0, 0);
      ehp = 2'd0;
      @(negedge clk);
      chk("enemy_ko_next_clk", phase, PH_ROUND_END);
      ehp = 2'd2; php = 2'd2;

      // Round 2: 2 vs 2 runs out the clock -> draw.
      expect_ph(PH_COUNTDOWN, 2, 1, 0, RES_PLAYER, CD, 1);
      wait_phase(PH_COUNTDOWN, 40, "r2_countdown");
      expect_ph(PH_PLAY, 2, 1, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "r2_play");
      expect_ph(PH_ROUND_END, 2, 1, 0, RES_DRAW, 0, 1);
      wait_phase(PH_ROUND_END, 120, "r2_timeout");
      php = 2'd3; ehp = 2'd3;

      // Round 3: both KO in the very cycle the clock hits zero -> draw.
      expect_ph(PH_COUNTDOWN, 3, 1, 0, RES_DRAW, CD, 1);
      wait_phase(PH_COUNTDOWN, 40, "r3_countdown");
      expect_ph(PH_PLAY, 3, 1, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "r3_play");
      expect_ph(PH_ROUND_END, 3, 1, 0, RES_DRAW, 0, 1);
      wait_tl(0, 120, "r3_clock_zero");
      php = 2'd0; ehp = 2'd0;
      @(negedge clk);
      chk("double_ko_at_expire", phase, PH_ROUND_END);
      php = 2'd3; ehp = 2'd3;

      // Round 4: player knocked out.
      expect_ph(PH_COUNTDOWN, 4, 1, 0, RES_DRAW, CD, 1);
      wait_phase(PH_COUNTDOWN, 40, "r4_countdown");
      expect_ph(PH_PLAY, 4, 1, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "r4_play");
      expect_ph(PH_ROUND_END, 4, 1, 1, RES_ENEMY, 0, 0);
      php = 2'd0;
      @(negedge clk);
      chk("player_ko_next_clk", phase, PH_ROUND_END);
      php = 2'd3;

      // Round 5: pause at time_left=3 with two frames in, freeze, resume, then pause+select.
      expect_ph(PH_COUNTDOWN, 5, 1, 1, RES_ENEMY, CD, 1);
      wait_phase(PH_COUNTDOWN, 40, "r5_countdown");
      expect_ph(PH_PLAY, 5, 1, 1, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "r5_play");
      wait_tl(3, 64, "r5_reach_3");
      nt = 0;
      while (nt < 2) begin
         @(posedge clk);
         if (tick) nt++;
      end
      @(negedge clk);
      expect_ph(PH_PAUSE, 5, 1, 1, RES_NONE, 3, 1);
      pau = 1'b1;
      wait_phase(PH_PAUSE, 8, "pause_enter");
      pau = 1'b0;
      repeat (160) @(negedge clk);
      chk("paused_time_left", tl, 3);
      chk("paused_play_en", play_en, 0);
      chk("paused_phase", phase, PH_PAUSE);
      expect_ph(PH_PLAY, 5, 1, 1, RES_NONE, 3, 1);
      pau = 1'b1;
      wait_phase(PH_PLAY, 8, "pause_resume");
      pau = 1'b0;
      nt = 0; k = 0;
      while (tl !== 7'd2 && k < 64) begin
         @(posedge clk);
         if (tick) nt++;
         @(negedge clk);
         k++;
      end
      chk("resume_ticks_to_boundary", nt, 2);
      repeat (3) @(negedge clk);
      expect_ph(PH_PAUSE, 5, 1, 1, RES_NONE, 0, 0);
      pau = 1'b1;
      wait_phase(PH_PAUSE, 8, "pause_again");
      pau = 1'b0;
      repeat (3) @(negedge clk);
      expect_ph(PH_IDLE, 0, 0, 0, RES_NONE, 0, 1);
      pau = 1'b1; sel = 1'b1;
      wait_phase(PH_IDLE, 8, "pause_select_to_idle");
      pau = 1'b0; sel = 1'b0;

      // Match 2: KO win, then 3 vs 1 timeout win -> MATCH_WIN.
      repeat (3) @(negedge clk);
      expect_ph(PH_COUNTDOWN, 1, 0, 0, RES_NONE, CD, 1);
      sel = 1'b1;
      wait_phase(PH_COUNTDOWN, 8, "m2_start");
      sel = 1'b0;
      expect_ph(PH_PLAY, 1, 0, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "m2_r1_play");
      expect_ph(PH_ROUND_END, 1, 1, 0, RES_PLAYER, 0, 0);
      ehp = 2'd0;
      wait_phase(PH_ROUND_END, 4, "m2_r1_ko");
      ehp = 2'd1; php = 2'd3;
      expect_ph(PH_COUNTDOWN, 2, 1, 0, RES_PLAYER, CD, 1);
      wait_phase(PH_COUNTDOWN, 40, "m2_r2_countdown");
      expect_ph(PH_PLAY, 2, 1, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "m2_r2_play");
      expect_ph(PH_ROUND_END, 2, 2, 0, RES_PLAYER, 0, 1);
      wait_phase(PH_ROUND_END, 120, "m2_r2_timeout");
      expect_ph(PH_MATCH_WIN, 2, 2, 0, RES_PLAYER, 0, 1);
      wait_phase(PH_MATCH_WIN, 40, "match_win");
      repeat (20) @(negedge clk);
      chk("match_win_held_phase", phase, PH_MATCH_WIN);
      chk("match_win_held_pw", pw, 2);
      chk("match_win_held_result", res, RES_PLAYER);
      expect_ph(PH_IDLE, 0, 0, 0, RES_NONE, 0, 1);
      sel = 1'b1;
      wait_phase(PH_IDLE, 8, "match_win_to_idle");
      sel = 1'b0;
      chk("idle_wins_cleared", pw, 0);

      // Match 3: synchronous reset in the middle of PLAY.
      ehp = 2'd3;
      repeat (3) @(negedge clk);
      expect_ph(PH_COUNTDOWN, 1, 0, 0, RES_NONE, CD, 1);
      sel = 1'b1;
      wait_phase(PH_COUNTDOWN, 8, "m3_start");
      sel = 1'b0;
      expect_ph(PH_PLAY, 1, 0, 0, RES_NONE, RS, 1);
      wait_phase(PH_PLAY, 64, "m3_play");
      repeat (5) @(negedge clk);
      expect_ph(PH_IDLE, 0, 0, 0, RES_NONE, 0, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_play_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      chk("scoreboard_drained", sb.size(), 0);
      chk("round_rst_pulse_count", rr_seen, 8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
